dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 72 +++++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 size codes,
// FSM state encoding and the captured-request record.
package dmem_responder_pkg;

    // Load size/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store size codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit word: store byte enables and replication,
// load extraction with sign/zero extension, and size/alignment legality.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        fmt_err
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves a value held (no latches).
    always_comb begin
        byte_en = '0;
        wword   = '0;
        rdata   = '0;
        fmt_err = 1'b0;
        shifted = rword >> {lane, 3'b000};

        if (we) begin
            case (funct3)
                F3_SB: begin
                    byte_en = 4'b0001 << lane;
                    wword   = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    fmt_err = lane[0];
                    byte_en = 4'b0011 << lane;
                    wword   = {2{wdata[15:0]}};
                end
                F3_SW: begin
                    fmt_err = (lane != 2'b00);
                    byte_en = 4'b1111;
                    wword   = wdata;
                end
                default: fmt_err = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  rdata = {{24{shifted[7]}}, shifted[7:0]};
                F3_LBU: rdata = {24'h0, shifted[7:0]};
                F3_LH: begin
                    fmt_err = lane[0];
                    rdata   = {{16{shifted[15]}}, shifted[15:0]};
                end
                F3_LHU: begin
                    fmt_err = lane[0];
                    rdata   = {16'h0, shifted[15:0]};
                end
                F3_LW: begin
                    fmt_err = (lane != 2'b00);
                    rdata   = rword;
                end
                default: fmt_err = 1'b1;
            endcase
        end

        // A rejected request must neither write nor return data
        if (fmt_err) begin
            byte_en = '0;
            rdata   = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory with a valid/ready request side, programmable wait
// states and a one-cycle response pulse carrying load data or an error flag.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        HAS_WAIT ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    dmem_req_t               cap_q, cap_d;
    logic [31:0]             resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic [31:0]             mem_q [DEPTH_WORDS];

    dmem_req_t               op;
    logic                    commit;
    logic                    range_err;
    logic                    req_err;
    logic                    mem_we;
    logic [IDX_W-1:0]        idx;
    logic [31:0]             rword;
    logic [3:0]              byte_en;
    logic [31:0]             wword;
    logic [31:0]             load_data;
    logic                    fmt_err;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request is used in IDLE and the captured copy afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op = '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
        end else begin
            op = cap_q;
        end
    end

    // Full-width compare so high addresses never alias onto low words
    assign range_err = ({2'b00, op.addr[31:2]} >= 32'(DEPTH_WORDS));
    assign idx       = op.addr[IDX_W+1:2];
    assign rword     = range_err ? 32'h0 : mem_q[idx];

    dmem_lane_align u_lane_align (
        .we      (op.we),
        .funct3  (op.funct3),
        .lane    (op.addr[1:0]),
        .wdata   (op.wdata),
        .rword   (rword),
        .byte_en (byte_en),
        .wword   (wword),
        .rdata   (load_data),
        .fmt_err (fmt_err)
    );

    assign req_err = fmt_err | range_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        commit       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cap_d = op;
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            resp_err_d   = req_err;
            resp_rdata_d = (req_err || op.we) ? 32'h0 : load_data;
        end
    end

    // Reset on the commit edge abandons the access, so it also blocks the write
    assign mem_we = commit & op.we & ~req_err & ~rst;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: the array has no reset; contents survive rst and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with one wait state and a
// small zero-wait instance, checking data, error flag, latency and idle outputs.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int W_A = 1;
    localparam int W_B = 0;
    localparam int DEPTH_A = 1024;
    localparam int DEPTH_B = 16;

    typedef struct {
        int          inst;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [1:0]  we;
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [2:0]  f3     [2];
    logic [1:0]  rvalid;
    logic [31:0] rdata  [2];
    logic [1:0]  rerr;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    sb_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(W_A)) u_dut_a (
        .clk        (clk),
        .rst        (rst[0]),
        .req_valid  (valid[0]),
        .req_ready  (ready[0]),
        .req_we     (we[0]),
        .req_addr   (addr[0]),
        .req_wdata  (wdata[0]),
        .req_funct3 (f3[0]),
        .resp_valid (rvalid[0]),
        .resp_rdata (rdata[0]),
        .resp_err   (rerr[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(W_B)) u_dut_b (
        .clk        (clk),
        .rst        (rst[1]),
        .req_valid  (valid[1]),
        .req_ready  (ready[1]),
        .req_we     (we[1]),
        .req_addr   (addr[1]),
        .req_wdata  (wdata[1]),
        .req_funct3 (f3[1]),
        .resp_valid (rvalid[1]),
        .resp_rdata (rdata[1]),
        .resp_err   (rerr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? W_A : W_B;
    endfunction

    // Response monitor: pops the scoreboard on every pulse, checks idle outputs otherwise
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rvalid[i]) begin
                if (sbq.size() == 0) begin
                    check("unexpected_resp", 32'(rvalid[i]), 32'd0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("resp_inst", i, e.inst);
                    check("resp_rdata", rdata[i], e.rdata);
                    check("resp_err", 32'(rerr[i]), 32'(e.err));
                    check("resp_latency", cyc, e.due);
                end
            end else if (rst == 2'b00) begin
                check("idle_rdata", rdata[i], 32'h0);
                check("idle_err", 32'(rerr[i]), 32'h0);
            end
        end
    end

    task automatic send(input int i, input logic we_i, input logic [2:0] fc,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd);
        int n;
        @(negedge clk);
        valid[i] = 1'b1;
        we[i]    = we_i;
        addr[i]  = a;
        wdata[i] = wd;
        f3[i]    = fc;
        n = 0;
        while (!ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[i]) begin
            check("accept_timeout", 32'(ready[i]), 32'd1);
        end else begin
            sbq.push_back('{inst: i, err: e_err, rdata: e_rd, due: cyc + wait_of(i) + 1});
        end
        @(posedge clk);
        #1;
        valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic send_wait(input int i, input logic we_i, input logic [2:0] fc,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic e_err, input logic [31:0] e_rd);
        send(i, we_i, fc, a, wd, e_err, e_rd);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 2'b11;
        valid = 2'b00;
        we    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
            f3[i]    = '0;
        end
        repeat (3) @(negedge clk);
        rst = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", 32'(ready[i]), 32'd1);
            check("reset_resp_valid", 32'(rvalid[i]), 32'd0);
        end

        // Basic store/load and sub-word lanes
        send_wait(0, 1'b1, F3_SW,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        send_wait(0, 1'b0, F3_LW,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        send_wait(0, 1'b1, F3_SB,  32'h13, 32'h80,       1'b0, 32'h0);
        send_wait(0, 1'b0, F3_LB,  32'h13, 32'h0,        1'b0, 32'hFFFFFF80);
        send_wait(0, 1'b0, F3_LBU, 32'h13, 32'h0,        1'b0, 32'h00000080);
        send_wait(0, 1'b0, F3_LW,  32'h10, 32'h0,        1'b0, 32'h80ADBEEF);

        // Misalignment and bad codes
        send_wait(0, 1'b0, F3_LH,  32'h11, 32'h0,        1'b1, 32'h0);
        send_wait(0, 1'b1, F3_SW,  32'h12, 32'h12345678, 1'b1, 32'h0);
        send_wait(0, 1'b0, F3_LW,  32'h10, 32'h0,        1'b0, 32'h80ADBEEF);
        send_wait(0, 1'b0, 3'b011, 32'h0,  32'h0,        1'b1, 32'h0);
        send_wait(0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0);

        // Range limit and no aliasing of high addresses
        send_wait(0, 1'b0, F3_LW,  32'h1000, 32'h0,      1'b1, 32'h0);
        send_wait(0, 1'b1, F3_SW,  32'h0,    32'hA5A5A5A5, 1'b0, 32'h0);
        send_wait(0, 1'b1, F3_SW,  32'h2000, 32'h5A5A5A5A, 1'b1, 32'h0);
        send_wait(0, 1'b0, F3_LW,  32'h0,    32'h0,      1'b0, 32'hA5A5A5A5);
        send_wait(0, 1'b0, F3_LW,  32'h40000000, 32'h0,  1'b1, 32'h0);

        // Halfword lanes
        send_wait(0, 1'b1, F3_SW,  32'h14, 32'h11223344, 1'b0, 32'h0);
        send_wait(0, 1'b1, F3_SH,  32'h16, 32'h0000ABCD, 1'b0, 32'h0);
        send_wait(0, 1'b0, F3_LH,  32'h16, 32'h0,        1'b0, 32'hFFFFABCD);
        send_wait(0, 1'b0, F3_LHU, 32'h16, 32'h0,        1'b0, 32'h0000ABCD);
        send_wait(0, 1'b0, F3_LB,  32'h15, 32'h0,        1'b0, 32'h00000033);
        send_wait(0, 1'b0, F3_LW,  32'h14, 32'h0,        1'b0, 32'hABCD3344);

        // Valid held high: accepts every WAIT+2 cycles, ready low in WAIT/RESP
        @(negedge clk);
        valid[0] = 1'b1;
        we[0]    = 1'b0;
        addr[0]  = 32'h10;
        f3[0]    = F3_LW;
        for (int k = 0; k < 6; k++) begin
            check("hold_ready", 32'(ready[0]), 32'((k % (W_A + 2)) == 0));
            if (ready[0]) begin
                sbq.push_back('{inst: 0, err: 1'b0, rdata: 32'h80ADBEEF, due: cyc + W_A + 1});
            end
            @(negedge clk);
        end
        valid[0] = 1'b0;
        drain();

        // Reset during WAIT abandons the store
        send_wait(0, 1'b1, F3_SW,  32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
        @(negedge clk);
        valid[0] = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'h20;
        wdata[0] = 32'h1;
        f3[0]    = F3_SW;
        check("rst_pre_ready", 32'(ready[0]), 32'd1);
        @(negedge clk);
        check("rst_wait_ready", 32'(ready[0]), 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0]   = 1'b0;
        valid[0] = 1'b0;
        check("rst_post_ready", 32'(ready[0]), 32'd1);
        check("rst_post_resp_valid", 32'(rvalid[0]), 32'd0);
        check("rst_post_rdata", rdata[0], 32'h0);
        repeat (3) @(negedge clk);
        send_wait(0, 1'b0, F3_LW,  32'h20, 32'h0,        1'b0, 32'hCAFEF00D);

        // Zero wait states, small array
        send_wait(1, 1'b1, F3_SW,  32'h0,  32'h11223344, 1'b0, 32'h0);
        send_wait(1, 1'b0, F3_LW,  32'h0,  32'h0,        1'b0, 32'h11223344);
        send_wait(1, 1'b0, F3_LW,  32'h40, 32'h0,        1'b1, 32'h0);
        send_wait(1, 1'b1, F3_SB,  32'h3D, 32'h000000F7, 1'b0, 32'h0);
        send_wait(1, 1'b0, F3_LBU, 32'h3D, 32'h0,        1'b0, 32'h000000F7);
        send_wait(1, 1'b0, F3_LB,  32'h3D, 32'h0,        1'b0, 32'hFFFFFFF7);
        send_wait(1, 1'b0, F3_LBU, 32'h2,  32'h0,        1'b0, 32'h00000022);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
